// File: rtl/rx_arq_receiver.sv
// Alternating-bit ARQ receiver: parity/sequence check of each frame, ACK/NACK
// handshake, and a small receive FIFO drained by the consumer.
module rx_arq_receiver #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_parity,
  input  logic                  rx_seq,
  input  logic                  rd_en,
  output logic                  rx_ready,
  output logic                  ack,
  output logic                  nack,
  output logic                  dup,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [3:0]            err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, CHECK, ACK, NACK} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_parity;
  logic                  cap_seq;
  logic                  exp_seq;
  logic [DATA_WIDTH-1:0] fifo [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  dup_q;
  logic                  par_err;
  logic                  is_dup;
  logic                  do_wr;
  logic                  do_rd;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    par_err = ^{cap_data, cap_parity};
    is_dup  = (cap_seq != exp_seq);
    // full is taken from the pre-edge count, so a same-cycle read never admits the write
    do_wr   = (state == CHECK) && !par_err && !full && !is_dup;
    do_rd   = rd_en && !empty;
  end

  assign rx_ready = (state == IDLE);
  assign ack      = (state == ACK);
  assign nack     = (state == NACK);
  assign dup      = dup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_data   <= '0;
      cap_parity <= 1'b0;
      cap_seq    <= 1'b0;
      exp_seq    <= 1'b0;
      dup_q      <= 1'b0;
      err_cnt    <= '0;
    end else begin
      dup_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            cap_data   <= rx_data;
            cap_parity <= rx_parity;
            cap_seq    <= rx_seq;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (par_err) begin
            state <= NACK;
            if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
          end else if (is_dup) begin
            state <= ACK;
            dup_q <= 1'b1;
          end else if (full) begin
            state <= NACK;
          end else begin
            state   <= ACK;
            exp_seq <= ~exp_seq;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_rd) begin
        rd_data <= fifo[rd_ptr];
        rd_ptr  <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) fifo[wr_ptr] <= cap_data;
  end

endmodule

// File: doc/rx_arq_receiver.md
RX_ARQ_RECEIVER -- requirements
Module: rx_arq_receiver

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, meaning the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4 (power of two), meaning the number of receive-FIFO entries.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port rx_valid, input, 1 bit, meaning a frame is presented on rx_data/rx_parity/rx_seq.
REQ-006 The block SHALL have port rx_data, input, DATA_WIDTH bits, the frame payload.
REQ-007 The block SHALL have port rx_parity, input, 1 bit, the even-parity bit over rx_data.
REQ-008 The block SHALL have port rx_seq, input, 1 bit, the alternating-bit sequence number.
REQ-009 The block SHALL have port rd_en, input, 1 bit, meaning the consumer requests one FIFO word.
REQ-010 The block SHALL have port rx_ready, output, 1 bit, meaning a frame will be accepted this cycle.
REQ-011 The block SHALL have port ack, output, 1 bit, a one-cycle frame-accepted pulse.
REQ-012 The block SHALL have port nack, output, 1 bit, a one-cycle retransmit-request pulse.
REQ-013 The block SHALL have port dup, output, 1 bit, a one-cycle duplicate-frame pulse, coincident with ack.
REQ-014 The block SHALL have port rd_data, output, DATA_WIDTH bits, the registered FIFO read word.
REQ-015 The block SHALL have port rd_valid, output, 1 bit, meaning rd_data is new this cycle.
REQ-016 The block SHALL have port empty, output, 1 bit, and port full, output, 1 bit, the FIFO status flags.
REQ-017 The block SHALL have port err_cnt, output, 4 bits, the saturating count of parity-error NACKs.

Function
REQ-018 The FSM SHALL have states IDLE, CHECK, ACK and NACK; rx_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE with rx_valid=1, the block SHALL capture rx_data, rx_parity and rx_seq at the clock edge and go to CHECK; rx_valid SHALL be ignored in every other state.
REQ-020 In CHECK, when the XOR of rx_data and rx_parity is 1 (parity error), the block SHALL go to NACK and increment err_cnt, saturating at 15.
REQ-021 In CHECK, with good parity and full=1, the block SHALL go to NACK without a write and without incrementing err_cnt.
REQ-022 In CHECK, with good parity, full=0 and seq equal to exp_seq, the block SHALL write the payload at wr_ptr, advance wr_ptr modulo DEPTH, toggle exp_seq and go to ACK.
REQ-023 In CHECK, with good parity and seq not equal to exp_seq, the block SHALL treat the frame as a duplicate: no write, exp_seq unchanged, dup asserted with ack, and a transition to ACK, even when full.
REQ-024 ACK and NACK SHALL last exactly one cycle, SHALL assert ack or nack respectively while in that state, and SHALL then return to IDLE.
REQ-025 Response latency SHALL be fixed: rx_valid sampled at edge E0 gives ack or nack high between edges E1 and E2, and rx_ready high again after E2; the minimum frame spacing is 3 cycles.
REQ-026 ack and nack SHALL never be high in the same cycle.
REQ-027 When rd_en=1 and empty=0, the block SHALL load rd_data from fifo[rd_ptr] at the edge, advance rd_ptr modulo DEPTH and pulse rd_valid for one cycle.
REQ-028 When rd_en=1 and empty=1, the read SHALL be ignored: rd_data held, rd_valid=0, no pointer change.
REQ-029 Occupancy SHALL be a count of width clog2(DEPTH)+1 bits; empty SHALL be count==0 and full SHALL be count==DEPTH.
REQ-030 A simultaneous write and read SHALL leave count unchanged.
REQ-031 The full check in CHECK SHALL use the count before that edge, so a same-cycle read does not admit the write.
REQ-032 Both pointers SHALL wrap from DEPTH-1 to 0.

Reset
REQ-033 While rst_n=0, the block SHALL immediately force: state IDLE; rx_ready=1; ack=0, nack=0, dup=0; rd_data=0, rd_valid=0; wr_ptr=0, rd_ptr=0, count=0; empty=1, full=0; exp_seq=0; err_cnt=0.
REQ-034 FIFO contents SHALL be left unreset.
REQ-035 Reset asserted in CHECK, ACK or NACK SHALL abort the frame with no write and no ack/nack pulse.

Verification
REQ-036 Scenario: after reset, frame data=0xA, parity=0, seq=0 -> ack pulse 2 cycles later, count=1, exp_seq=1; then rd_en -> rd_data=0xA, rd_valid=1, empty=1.
REQ-037 Scenario: frame data=0x7, parity=0 (bad) -> nack pulse, err_cnt=1, count unchanged; resend with parity=1, seq=0 -> ack.
REQ-038 Scenario: good frame seq=0 accepted, then the same frame seq=0 resent -> ack and dup high together, count stays 1.
REQ-039 Scenario: 4 good frames with alternating seq (0x1..0x4) -> full=1; a 5th new frame -> nack; 4 reads -> 0x1, 0x2, 0x3, 0x4 in order, empty=1; then 2 more write/read pairs exercise pointer wrap.
REQ-040 Scenario: 16 bad-parity frames -> err_cnt=15, holding at 15 (saturated).
REQ-041 Scenario: rst_n pulled low the cycle after rx_valid is accepted (in CHECK) -> no ack/nack, count=0, rx_ready=1 immediately.
